// File: rtl/ff_wr_arbiter.sv
// Round-robin write arbiter that owns a shared W-bit register loaded by one of N requesters.
// Define ARB_LOCK_EN to add lock_i, which lets a requester keep top priority after its write.
module ff_wr_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                   ck_i,
    input  logic                   rst_i,
    input  logic [N-1:0]           req_i,
    input  logic [N*W-1:0]         d_i,
`ifdef ARB_LOCK_EN
    input  logic [N-1:0]           lock_i,
`endif
    output logic [N-1:0]           gnt_o,
    output logic [N-1:0]           ack_o,
    output logic [W-1:0]           q_o,
    output logic                   busy_o,
    output logic [1:0]             dbg_state_o,
    output logic [$clog2(N)-1:0]   dbg_ptr_o
);

    localparam int PW = $clog2(N);
    localparam logic [N-1:0] ONE = N'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   g_q;
    logic [N-1:0]    gnt_q;
    logic [N-1:0]    ack_q;
    logic [W-1:0]    q_q;
    logic [PW-1:0]   win_d;

    // Scan from ptr upward with wrap; the lowest offset that is requesting wins.
    always_comb begin
        win_d = ptr_q;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_q) + k) % N]) begin
                win_d = PW'((int'(ptr_q) + k) % N);
            end
        end
    end

    always_ff @(posedge ck_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            q_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i != '0) begin
                        g_q     <= win_d;
                        gnt_q   <= ONE << win_d;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    gnt_q <= '0;
                    // A requester that withdrew gets no write and costs no priority.
                    if (req_i[g_q]) begin
                        q_q     <= d_i[g_q*W +: W];
                        ack_q   <= ONE << g_q;
                        state_q <= DONE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DONE: begin
                    ack_q   <= '0;
                    state_q <= IDLE;
`ifdef ARB_LOCK_EN
                    if (lock_i[g_q]) begin
                        ptr_q <= g_q;
                    end else begin
                        ptr_q <= (g_q == PW'(N - 1)) ? '0 : g_q + 1'b1;
                    end
`else
                    ptr_q <= (g_q == PW'(N - 1)) ? '0 : g_q + 1'b1;
`endif
                end
                default: begin
                    gnt_q   <= '0;
                    ack_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign ack_o       = ack_q;
    assign q_o         = q_q;
    assign busy_o      = (state_q != IDLE);
    assign dbg_state_o = state_q;
    assign dbg_ptr_o   = ptr_q;

endmodule
